// File: rtl/mil_rxd.sv
// MIL-STD-1553 Manchester II word receiver: finds the 3-bit sync, decodes 16 data bits
// plus odd parity, and reports each word as good (rx_valid) or dropped (rx_err).
module mil_rxd #(
  parameter int unsigned HALF_BIT = 25,
  parameter int unsigned SYNC_MIN = 60,
  parameter int unsigned SYNC_MAX = 110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RXP,
  input  logic        RXN,
  output logic [15:0] dat,
  output logic        rx_valid,
  output logic        rx_cw,
  output logic        rx_err,
  output logic        rx_busy
);

  localparam int unsigned RUN_W = $clog2(SYNC_MAX + 2);
  localparam int unsigned CNT_W = $clog2(3 * HALF_BIT);

  // run holds (length of current level - 1), so a previous run of N cycles reads N-1 at the edge
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(SYNC_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_LO  = RUN_W'(SYNC_MIN - 1);
  localparam logic [RUN_W-1:0] RUN_HI  = RUN_W'(SYNC_MAX - 1);

  localparam logic [CNT_W-1:0] CHK2    = CNT_W'(HALF_BIT + HALF_BIT / 2);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(3 * HALF_BIT - 1);
  localparam logic [CNT_W-1:0] SMP1    = CNT_W'(HALF_BIT / 2);
  localparam logic [CNT_W-1:0] SMP2    = CNT_W'(HALF_BIT + HALF_BIT / 2);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(2 * HALF_BIT - 1);
  localparam logic [4:0]       LAST_BIT = 5'd16;

  typedef enum logic [1:0] {L_INV = 2'b00, L_LO = 2'b01, L_HI = 2'b10} lvl_t;
  typedef enum logic [1:0] {IDLE, SYNC2, DATA, DONE} state_t;

  state_t           state;
  lvl_t             lvl, lvl_q, sync_lvl;
  logic             p_s1, p_s2, n_s1, n_s2;
  logic [RUN_W-1:0] run;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_idx;
  logic [15:0]      sr;
  logic             first_hi;
  logic             cw_flag;
  logic             sync_edge;

  always_comb begin
    lvl = L_INV;
    if (p_s2 != n_s2) lvl = p_s2 ? L_HI : L_LO;
  end

  always_comb begin
    sync_edge = (state == IDLE) && (lvl != L_INV) && (lvl_q != L_INV) && (lvl != lvl_q)
                && (run >= RUN_LO) && (run <= RUN_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_s1     <= 1'b0;
      p_s2     <= 1'b0;
      n_s1     <= 1'b0;
      n_s2     <= 1'b0;
      lvl_q    <= L_INV;
      sync_lvl <= L_INV;
      run      <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      sr       <= '0;
      first_hi <= 1'b0;
      cw_flag  <= 1'b0;
      state    <= IDLE;
      dat      <= '0;
      rx_valid <= 1'b0;
      rx_cw    <= 1'b0;
      rx_err   <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      p_s1     <= RXP;
      p_s2     <= p_s1;
      n_s1     <= RXN;
      n_s2     <= n_s1;
      lvl_q    <= lvl;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;

      // Run tracking never pauses, so a sync merged with the previous parity half is still seen
      if (lvl != lvl_q)        run <= '0;
      else if (run != RUN_SAT) run <= run + 1'b1;

      case (state)
        IDLE: begin
          if (sync_edge) begin
            state    <= SYNC2;
            cw_flag  <= (lvl_q == L_HI);
            sync_lvl <= lvl;
            cnt      <= CNT_W'(1);
            rx_busy  <= 1'b1;
          end
        end
        SYNC2: begin
          cnt <= cnt + 1'b1;
          if (cnt == CHK2 && lvl != sync_lvl) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else if (cnt == SYNC_END) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (cnt == SMP1) begin
            if (lvl == L_INV) begin
              rx_err  <= 1'b1;
              rx_busy <= 1'b0;
              state   <= IDLE;
            end else begin
              first_hi <= (lvl == L_HI);
            end
          end else if (cnt == SMP2) begin
            if (lvl == L_INV || (lvl == L_HI) == first_hi) begin
              rx_err  <= 1'b1;
              rx_busy <= 1'b0;
              state   <= IDLE;
            end else if (bit_idx == LAST_BIT) begin
              // Parity is judged at its own second-half sample so the pulse lands one cycle later
              rx_busy <= 1'b0;
              state   <= DONE;
              if (^{sr, first_hi}) begin
                dat      <= sr;
                rx_cw    <= cw_flag;
                rx_valid <= 1'b1;
              end else begin
                rx_err <= 1'b1;
              end
            end else begin
              sr <= {sr[14:0], first_hi};
            end
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mil_rxd.sv
// Bench for mil_rxd: drives Manchester words on RXP/RXN and checks every cycle against
// a word-level model (expected pulse cycle, type and held dat/rx_cw).
module tb_mil_rxd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RXP, RXN;
  logic [15:0] dat;
  logic        rx_valid, rx_cw, rx_err, rx_busy;

  mil_rxd #(.HALF_BIT(25), .SYNC_MIN(60), .SYNC_MAX(110)) dut (
    .clk(clk), .rst_n(rst_n), .RXP(RXP), .RXN(RXN),
    .dat(dat), .rx_valid(rx_valid), .rx_cw(rx_cw), .rx_err(rx_err), .rx_busy(rx_busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          is_err;
    logic [15:0] d;
    bit          cw;
  } exp_t;

  exp_t        expq[$];
  exp_t        e;
  logic [15:0] mdat = '0;
  bit          mcw = 1'b0;
  int          n_chk = 0, n_pass = 0;
  int          n_valid = 0, n_err = 0, busy_cnt = 0;
  int          last_valid_cyc = 0, prev_valid_cyc = 0, last_err_cyc = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Word-level model: pulse expected exactly at the scheduled cycle, dat/rx_cw held otherwise
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      mdat = '0;
      mcw  = 1'b0;
      check(dat == 16'h0 && !rx_cw && !rx_valid && !rx_err && !rx_busy, "reset_outputs",
            {12'h0, dat, rx_cw, rx_valid, rx_err, rx_busy}, 32'h0);
    end else begin
      if (rx_valid) begin n_valid++; prev_valid_cyc = last_valid_cyc; last_valid_cyc = cyc; end
      if (rx_err) begin n_err++; last_err_cyc = cyc; end
      if (rx_busy) busy_cnt++;
      if (expq.size() > 0 && expq[0].at == cyc) begin
        e = expq.pop_front();
        check(rx_valid == !e.is_err && rx_err == e.is_err && !rx_busy, "pulse",
              {29'h0, rx_valid, rx_err, rx_busy}, {29'h0, !e.is_err, e.is_err, 1'b0});
        if (!e.is_err) begin
          mdat = e.d;
          mcw  = e.cw;
        end
      end else begin
        check(!rx_valid && !rx_err, "no_pulse", {30'h0, rx_valid, rx_err}, 32'h0);
      end
      check(dat == mdat && rx_cw == mcw, "dat_cw", {15'h0, rx_cw, dat}, {15'h0, mcw, mdat});
    end
  end

  task automatic put(input bit p, input bit n, input int len);
    RXP = p;
    RXN = n;
    repeat (len) @(posedge clk);
    #1;
  endtask

  // force_i: that bit is sent as two HI halves; rst_i: rst_n pulsed low during that bit's first half
  task automatic send_word(input logic [15:0] w, input bit cw, input bit bad_par,
                           input int force_i, input int rst_i, output int c_mid);
    exp_t x;
    logic b;
    logic par;
    int   t;
    put(cw, !cw, 75);
    c_mid = cyc;
    put(!cw, cw, 75);
    t = c_mid + 2;
    if (force_i >= 0)  x = '{t + 75 + 50 * force_i + 38, 1'b1, w, cw};
    else if (bad_par)  x = '{t + 913, 1'b1, w, cw};
    else               x = '{t + 913, 1'b0, w, cw};
    expq.push_back(x);
    par = (~^w) ^ bad_par;
    for (int i = 0; i < 17; i++) begin
      b = (i < 16) ? w[15 - i] : par;
      if (i == force_i) begin
        put(1'b1, 1'b0, 50);
      end else begin
        if (i == rst_i) rst_n = 1'b0;
        put(b, !b, 25);
        if (i == rst_i) rst_n = 1'b1;
        put(!b, b, 25);
      end
    end
  endtask

  int cm, v0, e0, b0;

  initial begin
    rst_n = 1'b0;
    RXP   = 1'b0;
    RXN   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    put(1'b0, 1'b0, 20);

    // command word followed by a contiguous data word
    v0 = n_valid; e0 = n_err;
    send_word(16'h1234, 1'b1, 1'b0, -1, -1, cm);
    check(dat == 16'h1234 && rx_cw, "w1_dat", {15'h0, rx_cw, dat}, {15'h0, 1'b1, 16'h1234});
    check(last_valid_cyc - cm == 915, "w1_latency", last_valid_cyc - cm, 915);
    send_word(16'h5678, 1'b0, 1'b0, -1, -1, cm);
    put(1'b0, 1'b0, 60);
    check(dat == 16'h5678 && !rx_cw, "w2_dat", {15'h0, rx_cw, dat}, {15'h0, 1'b0, 16'h5678});
    check(last_valid_cyc - prev_valid_cyc == 1000, "w2_spacing", last_valid_cyc - prev_valid_cyc, 1000);
    check(n_valid - v0 == 2 && n_err == e0, "w12_counts", {n_valid - v0, n_err - e0}, {32'd2, 32'd0});

    // bad parity
    send_word(16'hFFFF, 1'b1, 1'b1, -1, -1, cm);
    put(1'b0, 1'b0, 60);
    check(last_err_cyc - cm == 915, "par_err_latency", last_err_cyc - cm, 915);
    check(dat == 16'h5678 && !rx_cw, "par_err_hold", {15'h0, rx_cw, dat}, {15'h0, 1'b0, 16'h5678});

    // Manchester error at bit 5, then a good word
    e0 = n_err;
    send_word(16'hA5A5, 1'b0, 1'b0, 5, -1, cm);
    put(1'b0, 1'b0, 100);
    check(last_err_cyc - cm == 365, "man_err_latency", last_err_cyc - cm, 365);
    check(n_err - e0 == 1, "man_err_count", n_err - e0, 1);
    send_word(16'h00FF, 1'b1, 1'b0, -1, -1, cm);
    put(1'b0, 1'b0, 60);
    check(dat == 16'h00FF && rx_cw, "after_err_dat", {15'h0, rx_cw, dat}, {15'h0, 1'b1, 16'h00FF});

    // runs too short and too long must not start a word
    b0 = busy_cnt; v0 = n_valid; e0 = n_err;
    put(1'b1, 1'b0, 30);
    put(1'b0, 1'b1, 40);
    put(1'b1, 1'b0, 120);
    put(1'b0, 1'b1, 40);
    put(1'b0, 1'b0, 50);
    check(busy_cnt == b0, "bad_run_busy", busy_cnt - b0, 0);
    check(n_valid == v0 && n_err == e0, "bad_run_pulses", {n_valid - v0, n_err - e0}, 0);

    // reset mid-word, then a data word
    v0 = n_valid; e0 = n_err;
    send_word(16'hBEEF, 1'b1, 1'b0, -1, 8, cm);
    put(1'b0, 1'b0, 60);
    check(dat == 16'h0000 && !rx_cw, "rst_abort_dat", {15'h0, rx_cw, dat}, 32'h0);
    check(n_valid == v0 && n_err == e0, "rst_abort_pulses", {n_valid - v0, n_err - e0}, 0);
    send_word(16'h0F0F, 1'b0, 1'b0, -1, -1, cm);
    put(1'b0, 1'b0, 60);
    check(dat == 16'h0F0F && !rx_cw, "post_rst_dat", {15'h0, rx_cw, dat}, {15'h0, 1'b0, 16'h0F0F});

    check(expq.size() == 0, "queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
